// File: rtl/nas_vid_capture.sv
// nas_vid_capture: recovers line/frame timing from a composite sync signal
// and samples the dot stream into an (x, y, data) pixel strobe.
module nas_vid_capture #(
  parameter int HSYNC_MIN = 32,
  parameter int VSYNC_MIN = 1024,
  parameter int H_OFFSET  = 128,
  parameter int H_PIXELS  = 384,
  parameter int DOT_DIV   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vid_sync,
  input  logic        vid_data,
  output logic        pix_valid,
  output logic        pix_data,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        sync_err
);

  typedef enum logic [1:0] {IDLE, WAIT_H, OFFSET, ACTIVE} state_t;

  localparam logic [11:0] HS_TH    = 12'(HSYNC_MIN);
  localparam logic [11:0] VS_TH    = 12'(VSYNC_MIN);
  localparam logic [15:0] OFF_LAST = 16'(H_OFFSET - 1);
  localparam logic [7:0]  DIV_LAST = 8'(DOT_DIV - 1);
  localparam logic [8:0]  X_LAST   = 9'(H_PIXELS - 1);
  localparam logic [8:0]  Y_MAX    = 9'd511;

  state_t      state_q, state_d;
  logic        sync_q, data_q;
  logic [11:0] width_q;
  logic [15:0] off_q, off_d;
  logic [7:0]  div_q, div_d;
  logic [8:0]  x_q, x_d;
  logic [8:0]  line_q, line_d;
  logic        inc_q, inc_d;
  logic        pix_valid_q, pix_valid_d;
  logic        pix_data_q, pix_data_d;
  logic [8:0]  pix_x_q, pix_x_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        err_q, err_d;

  logic sync_rise, sync_fall, is_vsync, is_hsync;

  // A non-zero width with sync back high marks the end of a pulse; a zero
  // width with sync low marks its first cycle.
  assign sync_rise = sync_q && (width_q != 12'd0);
  assign sync_fall = !sync_q && (width_q == 12'd0);
  assign is_vsync  = width_q >= VS_TH;
  assign is_hsync  = width_q >= HS_TH;

  // Input retiming; sync idles high so reset never fakes a pulse edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      data_q <= 1'b0;
    end else begin
      sync_q <= vid_sync;
      data_q <= vid_data;
    end
  end

  // Saturating low-width counter, cleared while sync is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q <= 12'd0;
    end else if (sync_q) begin
      width_q <= 12'd0;
    end else if (width_q != 12'hFFF) begin
      width_q <= width_q + 12'd1;
    end
  end

  // Line/frame sequencing: pixel timing first, then abort and pulse
  // classification override it.
  always_comb begin
    state_d       = state_q;
    off_d         = off_q;
    div_d         = div_q;
    x_d           = x_q;
    line_d        = line_q;
    inc_d         = 1'b0;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_x_d       = pix_x_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    err_d         = err_q;

    // Line number advances one cycle after the last pixel so that pixel
    // still carries its own line index.
    if (inc_q && (line_q != Y_MAX)) line_d = line_q + 9'd1;

    case (state_q)
      OFFSET: begin
        if (off_q == OFF_LAST) begin
          state_d = ACTIVE;
          div_d   = 8'd0;
          x_d     = 9'd0;
        end else begin
          off_d = off_q + 16'd1;
        end
      end
      ACTIVE: begin
        if (div_q == DIV_LAST) begin
          div_d       = 8'd0;
          pix_valid_d = 1'b1;
          pix_data_d  = data_q;
          pix_x_d     = x_q;
          if (x_q == X_LAST) begin
            state_d = WAIT_H;
            inc_d   = 1'b1;
          end else begin
            x_d = x_q + 9'd1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: ;
    endcase

    // Sync dropping mid-line abandons the rest of the line.
    if (sync_fall && ((state_q == OFFSET) || (state_q == ACTIVE))) begin
      state_d     = WAIT_H;
      err_d       = 1'b1;
      pix_valid_d = 1'b0;
      pix_data_d  = pix_data_q;
      pix_x_d     = pix_x_q;
      inc_d       = 1'b0;
      line_d      = (line_q == Y_MAX) ? line_q : line_q + 9'd1;
    end

    if (sync_rise) begin
      if (is_vsync) begin
        state_d       = WAIT_H;
        frame_start_d = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        line_d        = 9'd0;
        inc_d         = 1'b0;
      end else if (is_hsync) begin
        if (state_q == WAIT_H) begin
          state_d = OFFSET;
          off_d   = 16'd0;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      off_q         <= 16'd0;
      div_q         <= 8'd0;
      x_q           <= 9'd0;
      line_q        <= 9'd0;
      inc_q         <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= 1'b0;
      pix_x_q       <= 9'd0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      off_q         <= off_d;
      div_q         <= div_d;
      x_q           <= x_d;
      line_q        <= line_d;
      inc_q         <= inc_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_x_q       <= pix_x_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = line_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign sync_err    = err_q;

endmodule

// File: tb/tb_nas_vid_capture.sv
// Randomized bench for nas_vid_capture with a timing-level reference model.
module tb_nas_vid_capture;

  localparam int HS = 20;
  localparam int VS = 200;
  localparam int HO = 8;
  localparam int HP = 16;
  localparam int DD = 2;

  logic        clk, rst, vid_sync, vid_data;
  logic        pix_valid, pix_data, frame_start, sync_err;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] frame_count;

  nas_vid_capture #(
    .HSYNC_MIN(HS), .VSYNC_MIN(VS), .H_OFFSET(HO), .H_PIXELS(HP), .DOT_DIV(DD)
  ) dut (
    .clk(clk), .rst(rst), .vid_sync(vid_sync), .vid_data(vid_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .frame_count(frame_count), .sync_err(sync_err)
  );

  typedef struct {
    int   cyc;
    int   x;
    int   y;
    logic d;
  } pix_t;

  pix_t pixq[$];
  int   fsq[$];
  logic din_hist [0:65535];
  int   cyc;
  int   checks, failures;
  int   exp_frames, exp_line;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: drive inputs, take the edge, record output strobes.
  task automatic step(input logic s, input logic d);
    cyc++;
    vid_sync = s;
    vid_data = d;
    din_hist[cyc % 65536] = d;
    @(posedge clk);
    #1;
    if (pix_valid === 1'b1) pixq.push_back('{cyc, int'(pix_x), int'(pix_y), pix_data});
    if (frame_start === 1'b1) fsq.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'($urandom_range(0, 1)));
  endtask

  // Low for w cycles then high; r is the cycle whose input brought sync back high.
  task automatic send_pulse(input int w, output int r);
    repeat (w) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'($urandom_range(0, 1)));
    r = cyc;
  endtask

  // Pixel i of a line whose hsync ended at r appears at r+1+HO+DD*(i+1),
  // carrying the dot presented one cycle earlier.
  task automatic check_line(input int r);
    pix_t p;
    int   want_cyc;
    idle(HO + DD * HP + 4);
    for (int i = 0; i < HP; i++) begin
      checks++;
      if (pixq.size() == 0) begin
        failures++;
        $display("FAIL line_pixel y=%0d idx=%0d got none want pixel", exp_line, i);
        break;
      end
      p = pixq.pop_front();
      want_cyc = r + 1 + HO + DD * (i + 1);
      if (p.cyc !== want_cyc || p.x !== i || p.y !== exp_line ||
          p.d !== din_hist[(p.cyc - 1) % 65536]) begin
        failures++;
        $display("FAIL line_pixel got cyc=%0d x=%0d y=%0d d=%0b want cyc=%0d x=%0d y=%0d d=%0b",
                 p.cyc, p.x, p.y, p.d, want_cyc, i, exp_line, din_hist[(p.cyc - 1) % 65536]);
      end
    end
    checks++;
    if (pixq.size() != 0) begin
      failures++;
      $display("FAIL line_extra got %0d extra pixels want 0", pixq.size());
    end
    pixq.delete();
    exp_line = (exp_line < 511) ? exp_line + 1 : 511;
    checks++;
    if (pix_y !== 9'(exp_line)) begin
      failures++;
      $display("FAIL line_y_inc got %0d want %0d", pix_y, exp_line);
    end
  endtask

  task automatic test_line(input int w);
    int r;
    pixq.delete();
    send_pulse(w, r);
    check_line(r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vid_sync = 1'b1;
    vid_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pix_valid, pix_data, pix_x, pix_y, frame_start, frame_count, sync_err} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b d=%0b x=%0d y=%0d fs=%0b fc=%0d err=%0b want all 0",
               pix_valid, pix_data, pix_x, pix_y, frame_start, frame_count, sync_err);
    end
    rst = 1'b0;
    idle(2);
  endtask

  // Without a vsync since reset, hsyncs must not start any line.
  task automatic test_idle_ignore();
    int r;
    pixq.delete();
    send_pulse(HS + $urandom_range(0, 40), r);
    idle(HO + DD * HP + 6);
    checks++;
    if (pixq.size() != 0 || frame_count !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL idle_ignore got pixels=%0d fc=%0d want pixels=0 fc=%0d",
               pixq.size(), frame_count, exp_frames);
    end
  endtask

  task automatic test_vsync(input int w);
    int r;
    fsq.delete();
    send_pulse(w, r);
    idle(3);
    exp_frames++;
    exp_line = 0;
    checks++;
    if (fsq.size() != 1 || fsq[0] != r + 1) begin
      failures++;
      $display("FAIL vsync_frame_start got strobes=%0d first=%0d want 1 at %0d",
               fsq.size(), (fsq.size() > 0) ? fsq[0] : -1, r + 1);
    end
    checks++;
    if (frame_count !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL vsync_frame_count got %0d want %0d", frame_count, exp_frames);
    end
    checks++;
    if (pix_y !== 9'd0) begin
      failures++;
      $display("FAIL vsync_pix_y got %0d want 0", pix_y);
    end
  endtask

  task automatic test_glitch();
    int r;
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL glitch_pre_err got %0b want 0", sync_err);
    end
    pixq.delete();
    send_pulse($urandom_range(1, HS - 1), r);
    idle(HO + DD * HP + 6);
    checks++;
    if (sync_err !== 1'b1 || pixq.size() != 0) begin
      failures++;
      $display("FAIL glitch got err=%0b pixels=%0d want err=1 pixels=0", sync_err, pixq.size());
    end
    test_line(HS + $urandom_range(0, VS - HS - 1));
  endtask

  task automatic test_abort();
    int r, a, n, last_x;
    bit seen;
    a = $urandom_range(1, HP - 2);
    pixq.delete();
    send_pulse(HS + $urandom_range(0, 5), r);
    seen = 0;
    for (int k = 0; k < HO + DD * HP + 10 && !seen; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      if (pixq.size() > 0 && pixq[$].x == a) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL abort_reach got no pixel x=%0d want reached", a);
    end
    send_pulse(HS + $urandom_range(0, 5), r);
    step(1'b1, 1'($urandom_range(0, 1)));
    n = pixq.size();
    last_x = (n > 0) ? pixq[$].x : -1;
    checks++;
    if (n != a + 1 || last_x != a) begin
      failures++;
      $display("FAIL abort_stop got count=%0d last_x=%0d want count=%0d last_x=%0d", n, last_x, a + 1, a);
    end
    checks++;
    if (sync_err !== 1'b1) begin
      failures++;
      $display("FAIL abort_err got %0b want 1", sync_err);
    end
    exp_line = (exp_line < 511) ? exp_line + 1 : 511;
    checks++;
    if (pix_y !== 9'(exp_line)) begin
      failures++;
      $display("FAIL abort_y got %0d want %0d", pix_y, exp_line);
    end
    pixq.delete();
    check_line(r);
  endtask

  task automatic test_saturate();
    int r;
    for (int l = 0; l < 520; l++) begin
      send_pulse(HS + $urandom_range(0, 8), r);
      idle(HO + DD * HP + 3);
      pixq.delete();
    end
    exp_line = (exp_line + 520 > 511) ? 511 : exp_line + 520;
    checks++;
    if (pix_y !== 9'(exp_line)) begin
      failures++;
      $display("FAIL saturate_y got %0d want %0d", pix_y, exp_line);
    end
    test_vsync(VS + $urandom_range(0, 100));
  endtask

  task automatic test_reset_mid();
    int r;
    send_pulse(HS + 3, r);
    idle(HO + DD * 5);
    rst = 1'b1;
    #2;
    checks++;
    if ({pix_valid, pix_data, pix_x, pix_y, frame_start, frame_count, sync_err} !== 37'd0) begin
      failures++;
      $display("FAIL reset_mid got v=%0b d=%0b x=%0d y=%0d fs=%0b fc=%0d err=%0b want all 0",
               pix_valid, pix_data, pix_x, pix_y, frame_start, frame_count, sync_err);
    end
    idle(2);
    rst = 1'b0;
    exp_frames = 0;
    exp_line = 0;
    pixq.delete();
    fsq.delete();
    test_idle_ignore();
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_err got %0b want 0", sync_err);
    end
    test_vsync(VS + $urandom_range(0, 50));
    test_line(HS + $urandom_range(0, 30));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    exp_frames = 0;
    exp_line = 0;
    test_reset();
    test_idle_ignore();
    test_vsync(4200);
    test_line(HS);
    test_line(VS - 1);
    test_glitch();
    test_vsync(VS);
    test_line(HS + $urandom_range(0, VS - HS - 1));
    test_abort();
    test_saturate();
    test_line(HS + $urandom_range(0, 20));
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
